// File: rtl/xrv1_pkg.sv
// rtl/xrv1_pkg.sv - shared types and constants for the xrv1 fetch redirect path
//
// Contents:
//   XRV1_SPEC_DEPTH     default number of in-flight static predictions
//   xrv1_redir_state_e  redirect sequencer states
package xrv1_pkg;

    localparam int XRV1_SPEC_DEPTH = 4;

    typedef enum logic [1:0] {
        BOOT,
        RUN,
        REDIR_SPEC,
        REDIR_FLUSH
    } xrv1_redir_state_e;

endpackage

// File: rtl/xrv1_fetch_redirect_ctrl_if.sv
// rtl/xrv1_fetch_redirect_ctrl_if.sv - fetch PC redirect handshake channel
//
// Signals:
//   fetch_pc_vld  redirect request pending (driven by the controller)
//   fetch_pc      redirect target (driven by the controller)
//   fetch_pc_rdy  fetch accepts the redirect (driven by fetch)
// Modports:
//   master  redirect controller side
//   slave   fetch PC register side
interface xrv1_fetch_redirect_ctrl_if;
    logic        fetch_pc_vld;
    logic [31:0] fetch_pc;
    logic        fetch_pc_rdy;

    modport master (output fetch_pc_vld, output fetch_pc, input fetch_pc_rdy);
    modport slave  (input fetch_pc_vld, input fetch_pc, output fetch_pc_rdy);
endinterface

// File: rtl/xrv1_spec_fifo.sv
// rtl/xrv1_spec_fifo.sv - in-order FIFO of 32-bit predicted PCs
//
// Ports:
//   clk_i, rst_n_i   clock, synchronous active-low reset
//   push_i, push_data_i  write one entry (ignored when full)
//   pop_i            drop the head entry (ignored when empty)
//   clear_i          empty the FIFO; wins over push and pop
//   head_o           oldest entry
//   full_o, empty_o  occupancy flags
//   count_o          number of valid entries
module xrv1_spec_fifo #(
    parameter int DEPTH = 4,
    localparam int PW = $clog2(DEPTH),
    localparam int CW = $clog2(DEPTH + 1)
) (
    input  logic          clk_i,
    input  logic          rst_n_i,
    input  logic          push_i,
    input  logic [31:0]   push_data_i,
    input  logic          pop_i,
    input  logic          clear_i,
    output logic [31:0]   head_o,
    output logic          full_o,
    output logic          empty_o,
    output logic [CW-1:0] count_o
);

    logic [31:0]   mem [DEPTH];
    logic [PW-1:0] wptr_q;
    logic [PW-1:0] rptr_q;
    logic [CW-1:0] count_q;
    logic          do_push;
    logic          do_pop;

    assign full_o  = (count_q == CW'(DEPTH));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign head_o  = mem[rptr_q];
    assign do_push = push_i & ~full_o;
    assign do_pop  = pop_i & ~empty_o;

    // Payload storage needs no reset: the count alone defines which entries are live.
    always_ff @(posedge clk_i) begin
        if (do_push) begin
            mem[wptr_q] <= push_data_i;
        end
    end

    // DEPTH is a power of two, so the pointers wrap naturally.
    always_ff @(posedge clk_i) begin
        if (!rst_n_i || clear_i) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            if (do_push) begin
                wptr_q <= wptr_q + PW'(1);
            end
            if (do_pop) begin
                rptr_q <= rptr_q + PW'(1);
            end
            count_q <= count_q + CW'(do_push) - CW'(do_pop);
        end
    end

endmodule

// File: rtl/xrv1_fetch_redirect_ctrl.sv
// rtl/xrv1_fetch_redirect_ctrl.sv - speculative PC redirect sequencer between decode, execute and fetch
//
// Ports:
//   clk_i, rst_n_i          clock, synchronous active-low reset
//   dec_vld_i               decode slot valid
//   spec_pc_vld_i, spec_pc_i  static prediction from decode
//   dec_stall_o             prediction not accepted this cycle (combinational)
//   exe_res_vld_i, exe_res_next_pc_i  in-order resolution of the oldest prediction
//   trap_vld_i, trap_pc_i   trap redirect, highest priority
//   fetch                   redirect handshake towards fetch (master modport)
//   flush_o                 one-cycle kill pulse after a mispredict or trap
//   spec_cnt_o              in-flight prediction count
//   mispred_cnt_o           saturating mispredict counter
//   err_o                   sticky: resolution arrived with no prediction in flight
module xrv1_fetch_redirect_ctrl
    import xrv1_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          SPEC_DEPTH = XRV1_SPEC_DEPTH,
    localparam int         CW         = $clog2(SPEC_DEPTH + 1)
) (
    input  logic                              clk_i,
    input  logic                              rst_n_i,
    input  logic                              dec_vld_i,
    input  logic                              spec_pc_vld_i,
    input  logic [31:0]                       spec_pc_i,
    output logic                              dec_stall_o,
    input  logic                              exe_res_vld_i,
    input  logic [31:0]                       exe_res_next_pc_i,
    input  logic                              trap_vld_i,
    input  logic [31:0]                       trap_pc_i,
    xrv1_fetch_redirect_ctrl_if.master        fetch,
    output logic                              flush_o,
    output logic [CW-1:0]                     spec_cnt_o,
    output logic [31:0]                       mispred_cnt_o,
    output logic                              err_o
);

    xrv1_redir_state_e state_q;
    logic              fetch_pc_vld_q;
    logic [31:0]       fetch_pc_q;
    logic              flush_q;
    logic [31:0]       mispred_cnt_q;
    logic              err_q;

    logic [31:0]       fifo_head;
    logic              fifo_full;
    logic              fifo_empty;
    logic              accept;
    logic              res_live;
    logic              mispredict;
    logic              res_pop;
    logic              err_set;
    logic              clear;
    logic              rdy;

    assign rdy = fetch.fetch_pc_rdy;

    // Stall uses the registered count, so a full FIFO stalls even if a pop lands this cycle.
    assign dec_stall_o = dec_vld_i & spec_pc_vld_i &
                         (fifo_full | (state_q == REDIR_FLUSH) | (state_q == BOOT) |
                          ((state_q == REDIR_SPEC) & ~rdy));
    assign accept      = dec_vld_i & spec_pc_vld_i & ~dec_stall_o;

    // A resolve is dropped under a same-cycle trap, and while a flush is pending
    // (everything it could refer to has already been killed).
    assign res_live   = exe_res_vld_i & ~trap_vld_i & (state_q != REDIR_FLUSH);
    assign mispredict = res_live & ~fifo_empty & (exe_res_next_pc_i != fifo_head);
    assign res_pop    = res_live & ~fifo_empty;
    assign err_set    = res_live & fifo_empty;
    assign clear      = trap_vld_i | mispredict;

    xrv1_spec_fifo #(
        .DEPTH (SPEC_DEPTH)
    ) u_spec_fifo (
        .clk_i       (clk_i),
        .rst_n_i     (rst_n_i),
        .push_i      (accept),
        .push_data_i (spec_pc_i),
        .pop_i       (res_pop),
        .clear_i     (clear),
        .head_o      (fifo_head),
        .full_o      (fifo_full),
        .empty_o     (fifo_empty),
        .count_o     (spec_cnt_o)
    );

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            state_q        <= BOOT;
            fetch_pc_vld_q <= 1'b1;
            fetch_pc_q     <= RESET_PC;
            flush_q        <= 1'b0;
            mispred_cnt_q  <= '0;
            err_q          <= 1'b0;
        end else begin
            flush_q <= clear;
            if (err_set) begin
                err_q <= 1'b1;
            end
            if (mispredict && (mispred_cnt_q != 32'hFFFF_FFFF)) begin
                mispred_cnt_q <= mispred_cnt_q + 32'd1;
            end

            if (trap_vld_i) begin
                state_q        <= REDIR_FLUSH;
                fetch_pc_vld_q <= 1'b1;
                fetch_pc_q     <= trap_pc_i;
            end else if (mispredict) begin
                state_q        <= REDIR_FLUSH;
                fetch_pc_vld_q <= 1'b1;
                fetch_pc_q     <= exe_res_next_pc_i;
            end else begin
                case (state_q)
                    BOOT, REDIR_FLUSH: begin
                        if (rdy) begin
                            state_q        <= RUN;
                            fetch_pc_vld_q <= 1'b0;
                        end
                    end
                    RUN: begin
                        if (accept) begin
                            state_q        <= REDIR_SPEC;
                            fetch_pc_vld_q <= 1'b1;
                            fetch_pc_q     <= spec_pc_i;
                        end
                    end
                    REDIR_SPEC: begin
                        // accept here implies rdy: the old target is consumed and replaced.
                        if (accept) begin
                            fetch_pc_q <= spec_pc_i;
                        end else if (rdy) begin
                            state_q        <= RUN;
                            fetch_pc_vld_q <= 1'b0;
                        end
                    end
                    default: begin
                        state_q <= BOOT;
                    end
                endcase
            end
        end
    end

    assign fetch.fetch_pc_vld = fetch_pc_vld_q;
    assign fetch.fetch_pc     = fetch_pc_q;
    assign flush_o            = flush_q;
    assign mispred_cnt_o      = mispred_cnt_q;
    assign err_o              = err_q;

endmodule

// File: tb/tb_xrv1_fetch_redirect_ctrl.sv
// tb/tb_xrv1_fetch_redirect_ctrl.sv - self-checking bench for xrv1_fetch_redirect_ctrl
module tb_xrv1_fetch_redirect_ctrl;

    localparam int          DEPTH = 4;
    localparam logic [31:0] RPC   = 32'h0000_0000;

    logic        clk;
    logic        rst_n;
    logic        dec_vld;
    logic        spec_vld;
    logic [31:0] spec_pc;
    logic        dec_stall;
    logic        res_vld;
    logic [31:0] res_pc;
    logic        trap;
    logic [31:0] trap_pc;
    logic        flush;
    logic [2:0]  spec_cnt;
    logic [31:0] mis_cnt;
    logic        err;

    int checks = 0;
    int errors = 0;

    xrv1_fetch_redirect_ctrl_if fif ();

    xrv1_fetch_redirect_ctrl #(
        .RESET_PC   (RPC),
        .SPEC_DEPTH (DEPTH)
    ) dut (
        .clk_i             (clk),
        .rst_n_i           (rst_n),
        .dec_vld_i         (dec_vld),
        .spec_pc_vld_i     (spec_vld),
        .spec_pc_i         (spec_pc),
        .dec_stall_o       (dec_stall),
        .exe_res_vld_i     (res_vld),
        .exe_res_next_pc_i (res_pc),
        .trap_vld_i        (trap),
        .trap_pc_i         (trap_pc),
        .fetch             (fif),
        .flush_o           (flush),
        .spec_cnt_o        (spec_cnt),
        .mispred_cnt_o     (mis_cnt),
        .err_o             (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: a queue of outstanding predictions plus one pending redirect
    // (kind 0 = boot, 1 = speculative, 2 = flush).
    logic [31:0] mq[$];
    bit          m_pend;
    int          m_kind;
    logic [31:0] m_pc;
    bit          m_flush;
    logic [31:0] m_mis;
    bit          m_err;

    task automatic model_reset();
        mq.delete();
        m_pend  = 1'b1;
        m_kind  = 0;
        m_pc    = RPC;
        m_flush = 1'b0;
        m_mis   = 32'd0;
        m_err   = 1'b0;
    endtask

    function automatic bit model_stall();
        bit blocked;
        blocked = (mq.size() == DEPTH) || (m_pend && m_kind != 1) ||
                  (m_pend && m_kind == 1 && !fif.fetch_pc_rdy);
        return dec_vld && spec_vld && blocked;
    endfunction

    task automatic model_step();
        bit acc;
        bit live;
        acc     = dec_vld && spec_vld && !model_stall();
        live    = res_vld && !trap && !(m_pend && m_kind == 2);
        m_flush = 1'b0;
        if (trap) begin
            mq.delete();
            m_pend = 1'b1; m_kind = 2; m_pc = trap_pc; m_flush = 1'b1;
        end else if (live && mq.size() > 0 && res_pc != mq[0]) begin
            mq.delete();
            m_pend = 1'b1; m_kind = 2; m_pc = res_pc; m_flush = 1'b1;
            if (m_mis != 32'hFFFF_FFFF) m_mis = m_mis + 32'd1;
        end else begin
            if (live && mq.size() == 0) m_err = 1'b1;
            if (live && mq.size() > 0) void'(mq.pop_front());
            if (m_pend && fif.fetch_pc_rdy) m_pend = 1'b0;
            if (acc) begin
                mq.push_back(spec_pc);
                m_pend = 1'b1; m_kind = 1; m_pc = spec_pc;
            end
        end
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_model_regs();
        chk("m_vld", 32'(fif.fetch_pc_vld), 32'(m_pend));
        if (m_pend) chk("m_pc", fif.fetch_pc, m_pc);
        chk("m_flush", 32'(flush), 32'(m_flush));
        chk("m_cnt", 32'(spec_cnt), 32'(mq.size()));
        chk("m_mis", mis_cnt, m_mis);
        chk("m_err", 32'(err), 32'(m_err));
    endtask

    task automatic idle_inputs();
        dec_vld = 0; spec_vld = 0; spec_pc = '0;
        res_vld = 0; res_pc = '0; trap = 0; trap_pc = '0;
        fif.fetch_pc_rdy = 1'b1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        idle_inputs();
        @(posedge clk);
        #1;
        model_reset();
        rst_n = 1'b1;
        check_model_regs();
    endtask

    // One cycle with inputs already applied: combinational stall, then registered outputs.
    task automatic model_cycle();
        #1;
        chk("m_stall", 32'(dec_stall), 32'(model_stall()));
        model_step();
        @(posedge clk);
        #1;
        check_model_regs();
    endtask

    typedef struct {
        bit          dv;
        bit          sv;
        logic [31:0] sp;
        bit          rv;
        logic [31:0] rp;
        bit          tv;
        logic [31:0] tp;
        bit          rdy;
        bit          e_stall;
        bit          e_vld;
        logic [31:0] e_pc;
        bit          e_flush;
        int          e_cnt;
        logic [31:0] e_mis;
        bit          e_err;
    } vec_t;

    function automatic vec_t mk(input bit dv, input bit sv, input logic [31:0] sp,
                                input bit rv, input logic [31:0] rp,
                                input bit tv, input logic [31:0] tp, input bit rdy,
                                input bit es, input bit ev, input logic [31:0] epc,
                                input bit ef, input int ec, input logic [31:0] em, input bit ee);
        vec_t v;
        v.dv = dv; v.sv = sv; v.sp = sp; v.rv = rv; v.rp = rp; v.tv = tv; v.tp = tp;
        v.rdy = rdy; v.e_stall = es; v.e_vld = ev; v.e_pc = epc; v.e_flush = ef;
        v.e_cnt = ec; v.e_mis = em; v.e_err = ee;
        return v;
    endfunction

    vec_t tbl[20];

    initial begin
        //            dv sv sp       rv rp       tv tp      rdy st vld pc      fl cnt mis err
        tbl[0]  = mk(0, 0, 32'h0,   0, 32'h0,   0, 32'h0,  1,  0, 0, 32'h0,   0, 0, 0, 0);
        tbl[1]  = mk(1, 1, 32'h100, 0, 32'h0,   0, 32'h0,  1,  0, 1, 32'h100, 0, 1, 0, 0);
        tbl[2]  = mk(0, 0, 32'h0,   0, 32'h0,   0, 32'h0,  1,  0, 0, 32'h0,   0, 1, 0, 0);
        tbl[3]  = mk(0, 0, 32'h0,   1, 32'h100, 0, 32'h0,  1,  0, 0, 32'h0,   0, 0, 0, 0);
        tbl[4]  = mk(1, 1, 32'h100, 0, 32'h0,   0, 32'h0,  1,  0, 1, 32'h100, 0, 1, 0, 0);
        tbl[5]  = mk(1, 1, 32'h200, 0, 32'h0,   0, 32'h0,  1,  0, 1, 32'h200, 0, 2, 0, 0);
        tbl[6]  = mk(0, 0, 32'h0,   1, 32'h104, 0, 32'h0,  1,  0, 1, 32'h104, 1, 0, 1, 0);
        tbl[7]  = mk(0, 0, 32'h0,   0, 32'h0,   0, 32'h0,  1,  0, 0, 32'h0,   0, 0, 1, 0);
        tbl[8]  = mk(1, 1, 32'h10,  0, 32'h0,   0, 32'h0,  1,  0, 1, 32'h10,  0, 1, 1, 0);
        tbl[9]  = mk(1, 1, 32'h20,  0, 32'h0,   0, 32'h0,  1,  0, 1, 32'h20,  0, 2, 1, 0);
        tbl[10] = mk(1, 1, 32'h30,  0, 32'h0,   0, 32'h0,  1,  0, 1, 32'h30,  0, 3, 1, 0);
        tbl[11] = mk(1, 1, 32'h40,  0, 32'h0,   0, 32'h0,  1,  0, 1, 32'h40,  0, 4, 1, 0);
        tbl[12] = mk(1, 1, 32'h50,  1, 32'h10,  0, 32'h0,  1,  1, 0, 32'h0,   0, 3, 1, 0);
        tbl[13] = mk(1, 1, 32'h50,  0, 32'h0,   0, 32'h0,  1,  0, 1, 32'h50,  0, 4, 1, 0);
        tbl[14] = mk(1, 1, 32'h60,  1, 32'h104, 1, 32'h80, 0,  1, 1, 32'h80,  1, 0, 1, 0);
        tbl[15] = mk(1, 1, 32'h60,  0, 32'h0,   0, 32'h0,  0,  1, 1, 32'h80,  0, 0, 1, 0);
        tbl[16] = mk(1, 1, 32'h60,  0, 32'h0,   0, 32'h0,  0,  1, 1, 32'h80,  0, 0, 1, 0);
        tbl[17] = mk(1, 1, 32'h60,  0, 32'h0,   0, 32'h0,  1,  1, 0, 32'h0,   0, 0, 1, 0);
        tbl[18] = mk(0, 0, 32'h0,   1, 32'h0,   0, 32'h0,  1,  0, 0, 32'h0,   0, 0, 1, 1);
        tbl[19] = mk(0, 0, 32'h0,   0, 32'h0,   0, 32'h0,  1,  0, 0, 32'h0,   0, 0, 1, 1);

        rst_n = 1'b0;
        idle_inputs();
        repeat (2) @(posedge clk);
        do_reset();
        chk("reset_vld", 32'(fif.fetch_pc_vld), 32'd1);
        chk("reset_pc", fif.fetch_pc, RPC);
        chk("reset_cnt", 32'(spec_cnt), 32'd0);
        chk("reset_flush", 32'(flush), 32'd0);

        for (int i = 0; i < 20; i++) begin
            dec_vld = tbl[i].dv; spec_vld = tbl[i].sv; spec_pc = tbl[i].sp;
            res_vld = tbl[i].rv; res_pc = tbl[i].rp;
            trap = tbl[i].tv; trap_pc = tbl[i].tp;
            fif.fetch_pc_rdy = tbl[i].rdy;
            #1;
            chk($sformatf("row%0d_stall", i), 32'(dec_stall), 32'(tbl[i].e_stall));
            model_step();
            @(posedge clk);
            #1;
            chk($sformatf("row%0d_vld", i), 32'(fif.fetch_pc_vld), 32'(tbl[i].e_vld));
            if (tbl[i].e_vld) chk($sformatf("row%0d_pc", i), fif.fetch_pc, tbl[i].e_pc);
            chk($sformatf("row%0d_flush", i), 32'(flush), 32'(tbl[i].e_flush));
            chk($sformatf("row%0d_cnt", i), 32'(spec_cnt), 32'(tbl[i].e_cnt));
            chk($sformatf("row%0d_mis", i), mis_cnt, tbl[i].e_mis);
            chk($sformatf("row%0d_err", i), 32'(err), 32'(tbl[i].e_err));
            check_model_regs();
        end

        do_reset();
        chk("reset_clears_err", 32'(err), 32'd0);
        chk("reset_clears_mis", mis_cnt, 32'd0);

        // Mid-operation reset with predictions in flight and a redirect pending.
        idle_inputs();
        model_cycle();
        dec_vld = 1; spec_vld = 1; spec_pc = 32'h300; fif.fetch_pc_rdy = 1'b0;
        model_cycle();
        idle_inputs();
        do_reset();
        chk("midreset_vld", 32'(fif.fetch_pc_vld), 32'd1);
        chk("midreset_pc", fif.fetch_pc, RPC);
        chk("midreset_cnt", 32'(spec_cnt), 32'd0);

        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(0, 199) == 0) begin
                do_reset();
            end else begin
                dec_vld  = ($urandom_range(0, 1) == 1);
                spec_vld = ($urandom_range(0, 3) != 0);
                spec_pc  = {20'h0, 10'($urandom_range(0, 1023)), 2'b00};
                res_vld  = ($urandom_range(0, 2) == 0);
                if (mq.size() > 0 && $urandom_range(0, 3) != 0) res_pc = mq[0];
                else res_pc = {20'h0, 10'($urandom_range(0, 1023)), 2'b00};
                trap     = ($urandom_range(0, 15) == 0);
                trap_pc  = {16'h0, 14'($urandom_range(0, 16383)), 2'b00};
                fif.fetch_pc_rdy = ($urandom_range(0, 4) < 3);
                model_cycle();
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/xrv1_fetch_redirect_ctrl.md
# xrv1_fetch_redirect_ctrl

Sequences the speculative-PC path between decode, execute and fetch. Decode-stage static predictions (spec PC valid/target) are accepted as fetch redirects and recorded in an in-order prediction FIFO. Execute resolutions are checked against the FIFO head, and a mismatch triggers a flush and a corrected redirect. Traps override everything. The block sits between the decode-stage branch speculation logic and the fetch PC register.

## Interface
- `RESET_PC`, default 32'h0000_0000: first fetch PC after reset.
- `SPEC_DEPTH`, default 4: maximum in-flight predictions. Power of two, ≥2.
- `clk_i` in 1: clock.
- `rst_n_i` in 1: reset, synchronous, active-low.
- `dec_vld_i` in 1: decode slot holds a valid instruction.
- `spec_pc_vld_i` in 1: decode instruction is a branch/jump with a static target.
- `spec_pc_i` in 32: predicted next PC for that instruction.
- `dec_stall_o` out 1: prediction not accepted this cycle; decode must hold.
- `exe_res_vld_i` in 1: execute resolves the oldest predicted instruction (program order).
- `exe_res_next_pc_i` in 32: actual next PC of the resolved instruction.
- `trap_vld_i` in 1: trap/exception redirect.
- `trap_pc_i` in 32: trap handler PC.
- `fetch_pc_vld_o` out 1: redirect request pending.
- `fetch_pc_o` out 32: redirect target.
- `fetch_pc_rdy_i` in 1: fetch accepts redirect.
- `flush_o` out 1: one-cycle pulse; kill all younger-than-resolved work.
- `spec_cnt_o` out $clog2(SPEC_DEPTH+1): in-flight prediction count.
- `mispred_cnt_o` out 32: saturating mispredict counter.
- `err_o` out 1: sticky; resolution received with FIFO empty.

## Operation
- FIFO: SPEC_DEPTH entries of 32-bit predicted PC, with read/write pointers and a count. Push on accepted prediction; pop on `exe_res_vld_i`.
- Accept prediction when `dec_vld_i & spec_pc_vld_i & ~dec_stall_o`.
- `dec_stall_o = dec_vld_i & spec_pc_vld_i & (full | state==REDIR_FLUSH | state==BOOT | (state==REDIR_SPEC & ~fetch_pc_rdy_i))`.
- Resolve: compare `exe_res_next_pc_i` with the FIFO head.
  - Match: pop only.
  - Mismatch: mispredict. Clear FIFO, pulse `flush_o`, increment `mispred_cnt_o` (saturates at 32'hFFFF_FFFF), redirect to `exe_res_next_pc_i`.
- Resolve with FIFO empty: ignored; set `err_o`.
- Redirect priority, same cycle: trap > mispredict > decode prediction.
  - Trap: clear FIFO, pulse `flush_o`, redirect to `trap_pc_i`. A same-cycle resolve is discarded and does not count toward `mispred_cnt_o`.
- States:
  - BOOT: reset state. `fetch_pc_o=RESET_PC`, vld=1. On rdy → RUN.
  - RUN: no pending redirect.
    - Accepted prediction → REDIR_SPEC.
    - Mispredict or trap → REDIR_FLUSH.
  - REDIR_SPEC: holds the spec target.
    - On rdy: a new accepted prediction in the same cycle → REDIR_SPEC with the new target; else → RUN.
    - Mispredict or trap overrides the target → REDIR_FLUSH.
  - REDIR_FLUSH: holds the flush target. Decode predictions are not accepted.
    - A later trap overwrites the target and re-pulses `flush_o`.
    - Resolves are ignored (FIFO already cleared).
    - On rdy → RUN.
  - A trap in BOOT → REDIR_FLUSH.
- Simultaneous push and pop: count unchanged, both pointers advance.
- Full with simultaneous pop: push is still stalled (stall is computed from the registered count).

## Timing
- Reset (`rst_n_i` low at a rising edge) sets the following from the next cycle:
  - state=BOOT, `fetch_pc_vld_o=1`, `fetch_pc_o=RESET_PC`.
  - `flush_o=0`, `spec_cnt_o=0`, `mispred_cnt_o=0`, `err_o=0`, FIFO cleared.
- Reset mid-operation discards all pending state identically.
- Prediction accepted in cycle N → `fetch_pc_vld_o=1` with `fetch_pc_o=spec_pc_i` in N+1. `spec_cnt_o` increments in N+1.
- Mispredict or trap in cycle N → in N+1: `flush_o=1` (exactly one cycle), `fetch_pc_vld_o=1` with the target, `spec_cnt_o=0`.
- `fetch_pc_vld_o`/`fetch_pc_o` are registered and stable until the rdy cycle, except when overridden by a higher-priority redirect.
- Handshake completes in a cycle with vld & rdy. `fetch_pc_vld_o` drops in the next cycle unless a new redirect is loaded.
- `dec_stall_o` is combinational from inputs and registered state. No other outputs depend combinationally on inputs.
- FIFO pointers are $clog2(SPEC_DEPTH) bits and wrap modulo SPEC_DEPTH. Count is $clog2(SPEC_DEPTH+1) bits.

## Structure
- Shared `xrv1_pkg` holds:
  - `xrv1_redir_state_e` enum (BOOT, RUN, REDIR_SPEC, REDIR_FLUSH).
  - `XRV1_SPEC_DEPTH` default constant.
- One sub-module, `xrv1_spec_fifo`: parameterized 32-bit sync FIFO with push/pop/clear, full/empty and count, same clock/reset.
- Top level holds the FSM, compare logic, priority mux and counters.

## Test plan
- Reset release, rdy=1:
  - `fetch_pc_vld_o=1`, `fetch_pc_o=0` in the first cycle; vld=0 the cycle after; `spec_cnt_o=0`.
- Prediction accepted at cycle 10 (spec 0x100), rdy=1; then resolve with next_pc 0x100:
  - `fetch_pc_o=0x100` at cycle 11.
  - `spec_cnt_o` goes 1→0.
  - no `flush_o`; `mispred_cnt_o=0`.
- Two predictions in flight (0x100, 0x200); resolve first with 0x104:
  - next cycle: `flush_o` pulse, `fetch_pc_o=0x104`, `spec_cnt_o=0`, `mispred_cnt_o=1`.
- SPEC_DEPTH=4, four accepted predictions, fifth offered with a same-cycle pop:
  - fifth sees `dec_stall_o=1`.
  - fifth is accepted the next cycle; count reaches 4.
- Same cycle: trap (0x80), mispredict (0x104) and prediction, with rdy=0 for 3 cycles:
  - `fetch_pc_o=0x80` held for 3 cycles; single `flush_o` pulse; `mispred_cnt_o` unchanged.
  - `dec_stall_o=1` while the redirect is pending.
- Resolve with FIFO empty:
  - `err_o=1` and stays set; FIFO and `spec_cnt_o` unchanged.
  - reset clears `err_o`.
